layer_mac_engine: RTL and testbench

//  Sequencer and multiply-accumulate stage that sits directly downstream of the weight/bias store.
//  For one layer it drives the store's read strobes and indices, and fetches the matching input activations.

---
 rtl/layer_mac_if.sv | 31 +++
 rtl/layer_mac_engine.sv | 161 ++++++++++++++++
 tb/tb_layer_mac_engine.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_mac_if.sv
// Bus between layer_mac_engine, the weight/bias store, the activation buffer
// and the next layer's activation buffer.
interface layer_mac_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
);
    logic                      start;
    logic [5:0]                layer;
    logic [5:0]                num_inputs;
    logic [5:0]                act_addr;
    logic [DATA_W-1:0]         act_data;
    logic                      weight_en;
    logic                      bias_en;
    logic [5:0]                n;
    logic [5:0]                i;
    logic [DATA_W-1:0]         wt_data;
    logic [DATA_W-1:0]         bias_data;
    logic [DATA_W*LANES-1:0]   neuron_out;
    logic                      busy;
    logic                      done;

    modport master (
        output start, layer, num_inputs, act_data, wt_data, bias_data,
        input  act_addr, weight_en, bias_en, n, i, neuron_out, busy, done
    );

    modport slave (
        input  start, layer, num_inputs, act_data, wt_data, bias_data,
        output act_addr, weight_en, bias_en, n, i, neuron_out, busy, done
    );
endinterface

// File: rtl/layer_mac_engine.sv
// Layer sequencer + 4-lane Q6.10 MAC: reads weights/bias/activations, outputs saturated sums.
// Optional build macro LAYER_MAC_RELU_EN applies ReLU to the saturated outputs.
module layer_mac_engine #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 10,
    parameter int ACC_W      = 24,
    parameter int LANES      = 4,
    parameter int MAX_INPUTS = 4
) (
    input  logic       clk,
    input  logic       rst,
    layer_mac_if.slave bus
);
    // LANES is a power of two so the issue counter splits into {input, lane}.
    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = $clog2(MAX_INPUTS + 1);
    localparam int CNT_W  = IDX_W + LANE_W;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          n_in;
    logic [IDX_W-1:0]          n_clamp;
    logic [5:0]                layer_q;

    logic [IDX_W-1:0]          p_p0;
    logic [LANE_W-1:0]         lane_p0;
    logic                      last_p0;

    logic                      vld_p1;
    logic                      first_p1;
    logic [LANE_W-1:0]         lane_p1;
    logic signed [PROD_W-1:0]  wt_x_p1, act_x_p1, prod_p1, shr_p1;
    logic signed [SUM_W-1:0]   term_p1, base_p1, sum_p1;

    logic signed [ACC_W-1:0]   acc     [LANES];
    logic signed [ACC_W-1:0]   acc_nxt [LANES];
    logic [DATA_W*LANES-1:0]   out_q, out_nxt;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] hi, lo;
        hi = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
        lo = ~hi;
        if (v > hi)      return hi[ACC_W-1:0];
        else if (v < lo) return lo[ACC_W-1:0];
        else             return v[ACC_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi, lo;
        hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        lo = ~hi;
        if (v > hi)      return hi[DATA_W-1:0];
        else if (v < lo) return lo[DATA_W-1:0];
        else             return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] lane_out(input logic signed [ACC_W-1:0] v);
        logic signed [DATA_W-1:0] s;
        s = sat_out(v);
`ifdef LAYER_MAC_RELU_EN
        return s[DATA_W-1] ? '0 : s;
`else
        return s;
`endif
    endfunction

    assign p_p0    = cnt[CNT_W-1:LANE_W];
    assign lane_p0 = cnt[LANE_W-1:0];
    assign last_p0 = (cnt == ({n_in, {LANE_W{1'b0}}} - CNT_W'(1)));

    always_comb begin
        if (bus.num_inputs > 6'(MAX_INPUTS)) n_clamp = IDX_W'(MAX_INPUTS);
        else                                 n_clamp = IDX_W'(bus.num_inputs);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = (n_clamp == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (last_p0)   state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.weight_en  = 1'b0;
        bus.bias_en    = 1'b0;
        bus.i          = '0;
        bus.act_addr   = '0;
        bus.n          = layer_q;
        bus.busy       = (state != S_IDLE);
        bus.done       = (state == S_DONE);
        bus.neuron_out = out_q;
        if (state == S_ISSUE) begin
            bus.weight_en = 1'b1;
            bus.bias_en   = (p_p0 == '0);
            bus.i         = 6'(p_p0);
            bus.act_addr  = 6'(p_p0);
        end
    end

    // ---- stage p1: operands returned by store/buffer for last cycle's issue ----
    always_comb begin
        wt_x_p1  = {{DATA_W{bus.wt_data[DATA_W-1]}}, bus.wt_data};
        act_x_p1 = {{DATA_W{bus.act_data[DATA_W-1]}}, bus.act_data};
        prod_p1  = wt_x_p1 * act_x_p1;
        shr_p1   = prod_p1 >>> FRAC_W;
        term_p1  = {{(SUM_W-PROD_W){shr_p1[PROD_W-1]}}, shr_p1};
        if (first_p1) base_p1 = {{(SUM_W-DATA_W){bus.bias_data[DATA_W-1]}}, bus.bias_data};
        else          base_p1 = {{(SUM_W-ACC_W){acc[lane_p1][ACC_W-1]}}, acc[lane_p1]};
        sum_p1 = base_p1 + term_p1;
        out_nxt = '0;
        for (int l = 0; l < LANES; l++) begin
            acc_nxt[l] = (vld_p1 && (lane_p1 == LANE_W'(l))) ? sat_acc(sum_p1) : acc[l];
            out_nxt[l*DATA_W +: DATA_W] = lane_out(acc_nxt[l]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            n_in     <= '0;
            layer_q  <= '0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            lane_p1  <= '0;
            out_q    <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end else begin
            vld_p1   <= (state == S_ISSUE);
            lane_p1  <= lane_p0;
            first_p1 <= (p_p0 == '0);
            for (int l = 0; l < LANES; l++) acc[l] <= acc_nxt[l];
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        layer_q <= bus.layer;
                        n_in    <= n_clamp;
                        cnt     <= '0;
                        if (n_clamp == '0) out_q <= '0;
                    end
                end
                S_ISSUE: cnt   <= cnt + CNT_W'(1);
                // DRAIN folds in the final lane-3 operand, so publish the post-update sums.
                S_DRAIN: out_q <= out_nxt;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_mac_engine.sv
// Randomized scoreboard bench for layer_mac_engine with behavioural store/buffer models.
module tb_layer_mac_engine;
    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int MAXN   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] wmem [64][MAXN][LANES];
    logic [15:0] bmem [64][LANES];
    logic [15:0] amem [64];

    typedef struct {
        logic [63:0] out;
        int          cyc;
        int          wexp;
        int          bexp;
    } exp_t;
    exp_t sbq[$];

    layer_mac_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

    layer_mac_engine #(
        .DATA_W(16), .FRAC_W(10), .ACC_W(24), .LANES(4), .MAX_INPUTS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference: bias + sum(floor(w*x / 2^10)), accumulator clipped to 24-bit range, output to 16-bit.
    function automatic logic [63:0] model(input int lay, input int nn);
        logic [63:0] r;
        longint a, prod, o;
        r = '0;
        if (nn == 0) return r;
        for (int l = 0; l < LANES; l++) begin
            a = longint'($signed(bmem[lay][l]));
            for (int p = 0; p < nn; p++) begin
                prod = longint'($signed(wmem[lay][p][l])) * longint'($signed(amem[p]));
                a = clampl(a + (prod >>> 10), -8388608, 8388607);
            end
            o = clampl(a, -32768, 32767);
`ifdef LAYER_MAC_RELU_EN
            if (o < 0) o = 0;
`endif
            r[l*16 +: 16] = o[15:0];
        end
        return r;
    endfunction

    function automatic exp_t mk_exp(input int lay, input int num, input int scyc,
                                    input bit use_lit, input logic [63:0] lit);
        exp_t e;
        int nn;
        nn     = (num > MAXN) ? MAXN : num;
        e.out  = use_lit ? lit : model(lay, nn);
        e.cyc  = scyc + ((nn == 0) ? 1 : 4 * nn + 2);
        e.wexp = 4 * nn;
        e.bexp = (nn > 0) ? 4 : 0;
        return e;
    endfunction

    // Weight/bias store and activation buffer: one-cycle read latency, store lane counter k.
    logic       m_we, m_be;
    logic [5:0] m_n, m_i, m_a;
    int         m_k = 0;
    always begin
        @(negedge clk);
        m_we = bus.weight_en;
        m_be = bus.bias_en;
        m_n  = bus.n;
        m_i  = bus.i;
        m_a  = bus.act_addr;
        @(posedge clk);
        #1;
        bus.wt_data   = m_we ? wmem[int'(m_n)][int'(m_i)][m_k] : 16'($urandom);
        bus.bias_data = m_be ? bmem[int'(m_n)][m_k] : 16'($urandom);
        bus.act_data  = amem[int'(m_a)];
        m_k = m_we ? (m_k + 1) % LANES : 0;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, got, req, cyc);
        end
    endtask

    // Monitor: all comparisons happen here.
    int   wcnt = 0;
    int   bcnt = 0;
    exp_t me;
    always @(negedge clk) begin
        if (rst) begin
            wcnt = 0;
            bcnt = 0;
            chk("rst_weight_en", 64'(bus.weight_en), 64'd0);
            chk("rst_bias_en", 64'(bus.bias_en), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_done", 64'(bus.done), 64'd0);
            chk("rst_n", 64'(bus.n), 64'd0);
            chk("rst_i", 64'(bus.i), 64'd0);
            chk("rst_act_addr", 64'(bus.act_addr), 64'd0);
            chk("rst_neuron_out", bus.neuron_out, 64'd0);
        end else begin
            if (bus.weight_en) wcnt++;
            if (bus.bias_en) bcnt++;
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d, required no pass pending", cyc);
                end else begin
                    me = sbq.pop_front();
                    chk("neuron_out", bus.neuron_out, me.out);
                    chk("done_cycle", 64'(cyc), 64'(me.cyc));
                    chk("weight_en_cycles", 64'(wcnt), 64'(me.wexp));
                    chk("bias_en_cycles", 64'(bcnt), 64'(me.bexp));
                end
                wcnt = 0;
                bcnt = 0;
            end else if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done by cycle %0d, required done at %0d", cyc, sbq[0].cyc);
                void'(sbq.pop_front());
                wcnt = 0;
                bcnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200; t++) begin
            if (!bus.busy) break;
            tick();
        end
    endtask

    task automatic start_pass(input int lay, input int num, input bit push, input bit use_lit,
                              input logic [63:0] lit, output int scyc);
        scyc = cyc;
        if (push) sbq.push_back(mk_exp(lay, num, scyc, use_lit, lit));
        bus.start      = 1'b1;
        bus.layer      = 6'(lay);
        bus.num_inputs = 6'(num);
        tick();
        bus.start = 1'b0;
    endtask

    function automatic logic [15:0] rnd_w();
        if ($urandom_range(0, 1) == 1) return 16'($urandom);
        return 16'(int'($urandom_range(0, 4095)) - 2048);
    endfunction

    logic [63:0] lit;
    int          s, d, lay;

    initial begin
        bus.start = 1'b0;
        bus.layer = '0;
        bus.num_inputs = '0;
        for (int a = 0; a < 64; a++) begin
            amem[a] = '0;
            for (int l = 0; l < LANES; l++) begin
                bmem[a][l] = '0;
                for (int p = 0; p < MAXN; p++) wmem[a][p][l] = '0;
            end
        end
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Identity weights on layer 0.
        for (int p = 0; p < MAXN; p++)
            for (int l = 0; l < LANES; l++) wmem[0][p][l] = (p == l) ? 16'h0400 : 16'h0000;
        amem[0] = 16'h0400; amem[1] = 16'h0800; amem[2] = 16'hFC00; amem[3] = 16'h0000;
        lit = {16'h0000, 16'hFC00, 16'h0800, 16'h0400};
`ifdef LAYER_MAC_RELU_EN
        lit[47:32] = 16'h0000;
`endif
        wait_idle();
        start_pass(0, 4, 1'b1, 1'b1, lit, s);

        // Bias only, layer 1, two inputs.
        bmem[1][0] = 16'h00FE;
        bmem[1][1] = 16'h01F8;
        wait_idle();
        start_pass(1, 2, 1'b1, 1'b1, {32'h0, 16'h01F8, 16'h00FE}, s);

        // Saturation both ways on layer 2.
        for (int p = 0; p < MAXN; p++)
            for (int l = 0; l < LANES; l++) wmem[2][p][l] = 16'h7FFF;
        wait_idle();
        for (int p = 0; p < MAXN; p++) amem[p] = 16'h7FFF;
        start_pass(2, 4, 1'b1, 1'b1, {4{16'h7FFF}}, s);
        wait_idle();
        for (int p = 0; p < MAXN; p++) amem[p] = 16'h8001;
        lit = {4{16'h8000}};
`ifdef LAYER_MAC_RELU_EN
        lit = '0;
`endif
        start_pass(2, 4, 1'b1, 1'b1, lit, s);

        // Clamped and empty input counts.
        wait_idle();
        start_pass(0, 9, 1'b1, 1'b0, '0, s);
        wait_idle();
        start_pass(3, 0, 1'b1, 1'b0, '0, s);

        // Start held across the done cycle: accepted in the following idle cycle.
        wait_idle();
        start_pass(0, 1, 1'b1, 1'b0, '0, s);
        d = s + 6;
        while (cyc < d) tick();
        sbq.push_back(mk_exp(1, 3, d + 1, 1'b0, '0));
        bus.start = 1'b1;
        bus.layer = 6'd1;
        bus.num_inputs = 6'd3;
        tick();
        tick();
        bus.start = 1'b0;

        // Start while busy must not launch another pass.
        wait_idle();
        start_pass(2, 4, 1'b1, 1'b0, '0, s);
        tick();
        tick();
        bus.start = 1'b1;
        bus.layer = 6'd5;
        bus.num_inputs = 6'd2;
        tick();
        bus.start = 1'b0;

        // Randomized passes.
        for (int it = 0; it < 12; it++) begin
            wait_idle();
            lay = 10 + it;
            for (int l = 0; l < LANES; l++) begin
                bmem[lay][l] = rnd_w();
                for (int p = 0; p < MAXN; p++) wmem[lay][p][l] = rnd_w();
            end
            for (int p = 0; p < MAXN; p++) amem[p] = rnd_w();
            start_pass(lay, int'($urandom_range(0, 7)), 1'b1, 1'b0, '0, s);
        end

        // Abort mid-pass with reset, then recover.
        wait_idle();
        start_pass(2, 4, 1'b0, 1'b0, '0, s);
        while (cyc < s + 5) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        start_pass(11, 3, 1'b1, 1'b0, '0, s);

        for (int t = 0; t < 200 && sbq.size() != 0; t++) tick();
        repeat (10) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
